trigger_capture_buffer: RTL
===========================

TRIGGER_CAPTURE_BUFFER -- requirements
Module: trigger_capture_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, sample width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, buffer address width; DEPTH = 2^ADDR_WIDTH samples.
REQ-003 SHALL have parameter PRE_TRIGGER, default 256, pre-trigger sample count; legal range 1..DEPTH-1.
REQ-004 SHALL have port Clock, input, 1, single clock for all logic.
REQ-005 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port SampleIn, input, DATA_WIDTH, ADC sample word.
REQ-007 SHALL have port SampleValid, input, 1, SampleIn qualifier.
REQ-008 SHALL have port Arm, input, 1, one-cycle start-capture pulse.
REQ-009 SHALL have port Abort, input, 1, one-cycle cancel pulse.
REQ-010 SHALL have port Trigger, input, 1, synchronised external trigger level.
REQ-011 SHALL have port ForceTrigger, input, 1, one-cycle software trigger.
REQ-012 SHALL have port ReadEnable, input, 1, byte request from the UART transmitter.
REQ-013 SHALL have port DataOut, output, 8, readout byte.
REQ-014 SHALL have port DataValid, output, 1, one-cycle DataOut strobe.
REQ-015 SHALL have port DataReadyToSend, output, 1, a byte may be requested.
REQ-016 SHALL have port Armed, output, 1, high in WAIT_TRIG.
REQ-017 SHALL have port Triggered, output, 1, high in POSTTRIG or READOUT.
REQ-018 SHALL have port Busy, output, 1, high in any state other than IDLE.

Function
REQ-019 SHALL implement states IDLE, PRETRIG, WAIT_TRIG, POSTTRIG, READOUT.
REQ-020 IDLE: Arm -> PRETRIG; write pointer and sample counter (ADDR_WIDTH+1 bits) cleared.
REQ-021 PRETRIG/WAIT_TRIG/POSTTRIG: each SampleValid cycle writes SampleIn at the write pointer; pointer increments modulo DEPTH; SampleValid ignored in IDLE and READOUT.
REQ-022 PRETRIG -> WAIT_TRIG on the cycle the PRE_TRIGGER-th sample is written; triggers ignored in PRETRIG.
REQ-023 Trigger event = Trigger high while registered Trigger was low, or ForceTrigger; the edge register updates in every state, so a level already high at WAIT_TRIG entry does not fire.
REQ-024 WAIT_TRIG: a trigger event -> POSTTRIG; a sample valid on the trigger cycle is the first post-trigger sample; the counter restarts at that cycle.
REQ-025 POSTTRIG -> READOUT when DEPTH-PRE_TRIGGER post-trigger samples are written; read pointer loads the write pointer (the oldest sample).
REQ-026 READOUT emits DEPTH*DATA_WIDTH/8 bytes, oldest sample first, MSB byte first within each sample.
REQ-027 DataReadyToSend is high in READOUT when bytes remain and no byte is pending; ReadEnable is accepted only when DataReadyToSend is high, otherwise ignored.
REQ-028 Accepted ReadEnable at cycle t -> DataOut valid with DataValid high for exactly cycle t+1; DataReadyToSend low at t+1 and may reassert at t+2 (maximum one byte per 2 cycles).
REQ-029 After the final byte's DataValid, the block SHALL go to IDLE next cycle.
REQ-030 Abort in any state -> IDLE next cycle, with DataValid and DataReadyToSend low; Abort has priority over Arm, trigger and ReadEnable in the same cycle.
REQ-031 Arm outside IDLE SHALL be ignored.
REQ-032 ReadEnable held low SHALL stall readout indefinitely without losing bytes.

Reset
REQ-033 Reset SHALL asynchronously force IDLE, clear pointers, counters, byte index and trigger edge register, and drive every output to 0; buffer RAM contents are not reset.

Structure
REQ-034 A shared package SHALL hold the state enumeration and the BYTES_PER_SAMPLE = DATA_WIDTH/8 derivation.
REQ-035 Buffer storage SHALL be sub-module capture_ram: simple dual-port, synchronous 1-cycle read, inferred block RAM.

Verification (DATA_WIDTH=16, ADDR_WIDTH=3, PRE_TRIGGER=3)
REQ-036 Arm, then continuous samples 0,1,2,... with a Trigger edge on the cycle sample 10 is written -> Armed after sample 2; readout bytes 00 07 00 08 ... 00 0E (16 bytes); then IDLE.
REQ-037 Trigger rises during sample 1 and stays high, falls, then rises at sample 6 -> no fire until sample 6; readout samples 3..10.
REQ-038 No Trigger edge; ForceTrigger at sample 5 -> readout samples 2..9.
REQ-039 Abort after 5 bytes read -> IDLE next cycle, DataReadyToSend 0; re-Arm captures correctly.
REQ-040 Reset asserted mid-POSTTRIG -> Busy, Triggered, DataValid 0 without waiting for a Clock edge.
REQ-041 ReadEnable held high -> one DataValid every 2 cycles; ReadEnable gaps of 0..20 cycles -> identical byte sequence.

Source files
------------

// File: rtl/trigger_capture_buffer_pkg.sv
// Shared definitions for the trigger capture buffer.
// Holds the capture/readout state enumeration and the sample-to-byte
// size helpers used by the top level.
package trigger_capture_buffer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRETRIG   = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POSTTRIG  = 3'd3,
    ST_READOUT   = 3'd4
  } state_t;

  // Number of bytes emitted per captured sample.
  function automatic int unsigned bytes_per_sample(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Width of a byte index within a sample (never narrower than 1 bit).
  function automatic int unsigned byte_idx_width(input int unsigned n_bytes);
    return (n_bytes > 1) ? $clog2(n_bytes) : 1;
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Sample storage: simple dual-port RAM, one write port and one read port
// with a registered (1-cycle) read. Contents are intentionally not reset.
// Ports:
//   i_clk      - clock
//   i_wr_en    - write strobe
//   i_wr_addr  - write address
//   i_wr_data  - write data
//   i_rd_addr  - read address, data appears on o_rd_data next cycle
//   o_rd_data  - registered read data
module capture_ram
  import trigger_capture_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Block-RAM style: write and registered read share one clocked process.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/trigger_capture_buffer.sv
// Triggered circular capture buffer with byte-serial readout.
// Arm starts a capture of PRE_TRIGGER samples, then waits for a trigger
// (rising edge of Trigger or ForceTrigger), captures DEPTH-PRE_TRIGGER more
// samples and streams the whole buffer out oldest-first, MSB byte first.
// Ports:
//   Clock, Reset            - clock, asynchronous active-high reset
//   SampleIn, SampleValid   - ADC sample stream
//   Arm, Abort              - start / cancel pulses
//   Trigger, ForceTrigger   - external trigger level, software trigger pulse
//   ReadEnable              - byte request from the UART transmitter
//   DataOut, DataValid      - readout byte and its one-cycle strobe
//   DataReadyToSend         - a byte may be requested
//   Armed, Triggered, Busy  - status flags
module trigger_capture_buffer
  import trigger_capture_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned PRE_TRIGGER = 256
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] SampleIn,
  input  logic                  SampleValid,
  input  logic                  Arm,
  input  logic                  Abort,
  input  logic                  Trigger,
  input  logic                  ForceTrigger,
  input  logic                  ReadEnable,
  output logic [7:0]            DataOut,
  output logic                  DataValid,
  output logic                  DataReadyToSend,
  output logic                  Armed,
  output logic                  Triggered,
  output logic                  Busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam int unsigned BPS   = bytes_per_sample(DATA_WIDTH);
  localparam int unsigned BIW   = byte_idx_width(BPS);

  localparam logic [CW-1:0]  PRE_CNT   = CW'(PRE_TRIGGER);
  localparam logic [CW-1:0]  POST_CNT  = CW'(DEPTH - PRE_TRIGGER);
  localparam logic [CW-1:0]  DEPTH_CNT = CW'(DEPTH);
  localparam logic [BIW-1:0] LAST_BYTE = BIW'(BPS - 1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]         r_cnt;
  logic [BIW-1:0]        r_byte_idx;
  logic                  r_trig_d;
  logic [7:0]            r_data_out;
  logic                  r_data_valid;
  logic                  r_drts;
  logic                  r_armed;
  logic                  r_triggered;
  logic                  r_busy;

  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_wr_ptr_next;
  logic [CW-1:0]         w_cnt_inc;
  logic                  w_trig_event;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [7:0]            w_rd_byte;

  // Status flags {Armed, Triggered, Busy} for the state being entered.
  function automatic logic [2:0] status_of(input state_t s);
    return {s == ST_WAIT_TRIG, (s == ST_POSTTRIG) || (s == ST_READOUT), s != ST_IDLE};
  endfunction

  assign w_wr_en = SampleValid && !Abort &&
                   ((r_state == ST_PRETRIG) || (r_state == ST_WAIT_TRIG) ||
                    (r_state == ST_POSTTRIG));
  assign w_wr_ptr_next = r_wr_ptr + 1'b1;
  assign w_cnt_inc     = r_cnt + 1'b1;
  assign w_trig_event  = (Trigger && !r_trig_d) || ForceTrigger;
  assign w_accept      = (r_state == ST_READOUT) && r_drts && ReadEnable;

  capture_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk     (Clock),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (SampleIn),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  // Byte select, byte 0 being the most significant byte of the sample.
  always_comb begin
    w_rd_byte = '0;
    for (int unsigned b = 0; b < BPS; b++) begin
      if (r_byte_idx == BIW'(b)) begin
        w_rd_byte = w_rd_data[DATA_WIDTH-1-8*b -: 8];
      end
    end
  end

  // Capture/readout FSM. r_drts only rises after a full cycle in READOUT with
  // no accept, which is exactly the RAM read latency after r_rd_ptr moves.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_cnt        <= '0;
      r_byte_idx   <= '0;
      r_trig_d     <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_drts       <= 1'b0;
      {r_armed, r_triggered, r_busy} <= 3'b000;
    end else begin
      r_trig_d     <= Trigger;
      r_data_valid <= 1'b0;
      if (w_wr_en) begin
        r_wr_ptr <= w_wr_ptr_next;
      end
      if (Abort) begin
        r_state <= ST_IDLE;
        r_drts  <= 1'b0;
        {r_armed, r_triggered, r_busy} <= status_of(ST_IDLE);
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (Arm) begin
              r_wr_ptr <= '0;
              r_cnt    <= '0;
              r_state  <= ST_PRETRIG;
              {r_armed, r_triggered, r_busy} <= status_of(ST_PRETRIG);
            end
          end
          ST_PRETRIG: begin
            if (SampleValid) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == PRE_CNT) begin
                r_state <= ST_WAIT_TRIG;
                {r_armed, r_triggered, r_busy} <= status_of(ST_WAIT_TRIG);
              end
            end
          end
          ST_WAIT_TRIG: begin
            if (w_trig_event) begin
              // A sample on the trigger cycle is the first post-trigger sample.
              r_cnt <= SampleValid ? CW'(1) : '0;
              if (SampleValid && (POST_CNT == CW'(1))) begin
                r_state    <= ST_READOUT;
                r_rd_ptr   <= w_wr_ptr_next;
                r_cnt      <= '0;
                r_byte_idx <= '0;
                r_drts     <= 1'b0;
                {r_armed, r_triggered, r_busy} <= status_of(ST_READOUT);
              end else begin
                r_state <= ST_POSTTRIG;
                {r_armed, r_triggered, r_busy} <= status_of(ST_POSTTRIG);
              end
            end
          end
          ST_POSTTRIG: begin
            if (SampleValid) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == POST_CNT) begin
                // Slot after the last write holds the oldest sample.
                r_state    <= ST_READOUT;
                r_rd_ptr   <= w_wr_ptr_next;
                r_cnt      <= '0;
                r_byte_idx <= '0;
                r_drts     <= 1'b0;
                {r_armed, r_triggered, r_busy} <= status_of(ST_READOUT);
              end
            end
          end
          ST_READOUT: begin
            if (w_accept) begin
              r_data_out   <= w_rd_byte;
              r_data_valid <= 1'b1;
              r_drts       <= 1'b0;
              if (r_byte_idx == LAST_BYTE) begin
                r_byte_idx <= '0;
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_cnt      <= w_cnt_inc;
              end else begin
                r_byte_idx <= r_byte_idx + 1'b1;
              end
            end else if (r_cnt == DEPTH_CNT) begin
              r_state <= ST_IDLE;
              r_drts  <= 1'b0;
              {r_armed, r_triggered, r_busy} <= status_of(ST_IDLE);
            end else begin
              r_drts <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_drts  <= 1'b0;
            {r_armed, r_triggered, r_busy} <= status_of(ST_IDLE);
          end
        endcase
      end
    end
  end

  assign DataOut         = r_data_out;
  assign DataValid       = r_data_valid;
  assign DataReadyToSend = r_drts;
  assign Armed           = r_armed;
  assign Triggered       = r_triggered;
  assign Busy            = r_busy;

endmodule
